// File: rtl/lift_pkg.sv
// Shared constants for the lift job sequencer: last local addresses of the
// core's q/p/result sets, result width and the scheduler state encoding.
package lift_pkg;
  localparam logic [2:0] LIFT_Q_LAST   = 3'd5;
  localparam logic [2:0] LIFT_P_LAST   = 3'd6;
  localparam logic [2:0] LIFT_RES_LAST = 3'd6;
  localparam int         RES_W         = 30;

  localparam logic [2:0] ST_IDLE_ENC = 3'd0;
  localparam logic [2:0] ST_CRST_ENC = 3'd1;
  localparam logic [2:0] ST_CREL_ENC = 3'd2;
  localparam logic [2:0] ST_RUN_ENC  = 3'd3;
  localparam logic [2:0] ST_ERR_ENC  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_CRST = ST_CRST_ENC,
    ST_CREL = ST_CREL_ENC,
    ST_RUN  = ST_RUN_ENC,
    ST_ERR  = ST_ERR_ENC
  } lift_state_e;
endpackage

// File: rtl/lift_sched_if.sv
// Host-side job handshake of the lift sequencer: request with coefficient
// count, and busy/done/err status back to the host.
interface lift_sched_if #(parameter int CW = 12);
  logic          job_start;
  logic [CW:0]   job_num;
  logic          job_busy;
  logic          job_done;
  logic          job_err;

  modport master (output job_start, job_num, input job_busy, job_done, job_err);
  modport slave  (input job_start, job_num, output job_busy, job_done, job_err);
endinterface

// File: rtl/lift_sched_wdog.sv
// Progress watchdog: counts RUN cycles since the last completed set write and
// flags expiry on the last permitted cycle so the scheduler leaves RUN on time.
module lift_sched_wdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run) cnt <= cnt + 1'b1;
  end

  assign expired = run && !clr && (cnt == LAST);
endmodule

// File: rtl/lift_sched.sv
// Job-level sequencer for lift_big: resets/starts the core, maps its local
// addresses onto per-coefficient bank addresses and tracks set progress.
module lift_sched
  import lift_pkg::*;
#(
  parameter int CW      = 12,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  lift_sched_if.slave       job,
  output logic              core_rst,
  output logic              core_start,
  input  logic [2:0]        core_rd_addr_q,
  input  logic [2:0]        core_rd_addr_p,
  input  logic [2:0]        core_res_addr,
  input  logic              core_res_we,
  input  logic [RES_W-1:0]  core_res_data,
  output logic [CW+2:0]     mem_q_addr,
  output logic [CW+2:0]     mem_p_addr,
  output logic [CW+2:0]     res_addr,
  output logic              res_we,
  output logic [RES_W-1:0]  res_data
);
  localparam logic [CW:0] N_MAX = {1'b1, {CW{1'b0}}};
  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC + 1) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);

  lift_state_e   state, state_nx;
  logic [CW-1:0] num_m1, rd_idx, wr_idx;
  logic [RCW-1:0] crst_cnt;
  logic          prev_p6, prev_wr, done_q, done_nx, accept;
  logic          in_run, p6, wr_hit, rd_event, wr_event, last_wr, wd_clr, wd_expired;

  assign in_run   = (state == ST_RUN);
  assign p6       = (core_rd_addr_p == LIFT_P_LAST);
  assign wr_hit   = core_res_we && (core_res_addr == LIFT_RES_LAST);
  assign rd_event = in_run && p6 && !prev_p6;
  assign wr_event = in_run && wr_hit && !prev_wr;
  assign last_wr  = wr_event && (wr_idx == num_m1);
  assign wd_clr   = !in_run || wr_event;

  lift_sched_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .run     (in_run),
    .expired (wd_expired)
  );

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      ST_IDLE, ST_ERR: begin
        if (job.job_start) begin
          if (job.job_num == '0) begin
            done_nx  = 1'b1;
            state_nx = ST_IDLE;
          end else if (job.job_num > N_MAX) begin
            state_nx = ST_ERR;
          end else begin
            accept   = 1'b1;
            state_nx = ST_CRST;
          end
        end
      end
      ST_CRST: if (crst_cnt == RST_LAST) state_nx = ST_CREL;
      ST_CREL: state_nx = ST_RUN;
      ST_RUN: begin
        if (last_wr) begin
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
        end else if (wd_expired) begin
          state_nx = ST_ERR;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Read index saturates at the last set so core read-ahead re-reads it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      num_m1   <= '0;
      rd_idx   <= '0;
      wr_idx   <= '0;
      crst_cnt <= '0;
      prev_p6  <= 1'b0;
      prev_wr  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      done_q  <= done_nx;
      prev_p6 <= p6;
      prev_wr <= wr_hit;
      if (accept) begin
        num_m1   <= CW'(job.job_num - 1'b1);
        rd_idx   <= '0;
        wr_idx   <= '0;
        crst_cnt <= '0;
      end else begin
        if (state == ST_CRST) crst_cnt <= crst_cnt + 1'b1;
        if (rd_event && (rd_idx != num_m1)) rd_idx <= rd_idx + 1'b1;
        if (wr_event) wr_idx <= wr_idx + 1'b1;
      end
    end
  end

  assign core_rst     = !((state == ST_CREL) || in_run);
  assign core_start   = in_run;
  assign job.job_busy = (state == ST_CRST) || (state == ST_CREL) || in_run;
  assign job.job_err  = (state == ST_ERR);
  assign job.job_done = done_q;

  assign mem_q_addr = {rd_idx, core_rd_addr_q};
  assign mem_p_addr = {rd_idx, core_rd_addr_p};
  assign res_addr   = {wr_idx, core_res_addr};
  assign res_we     = core_res_we && in_run;
  assign res_data   = core_res_data;
endmodule

// File: tb/tb_lift_sched.sv
// Bench for lift_sched with a behavioural lift_big stand-in and two banks;
// expected bank writes are queued per job and checked as they appear.
module tb_lift_sched;
  import lift_pkg::*;

  localparam int CW = 4;
  localparam int NMAX = 1 << CW;
  localparam int TO = 64;
  localparam int DEPTH = 1 << (CW + 3);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lift_sched_if #(.CW(CW)) jif ();

  logic             core_rst, core_start, res_we;
  logic [2:0]       c_aq, c_ap, c_ra;
  logic             c_we;
  logic [RES_W-1:0] c_rd, res_data;
  logic [CW+2:0]    mem_q_addr, mem_p_addr, res_addr;

  lift_sched #(.CW(CW), .RST_CYC(2), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .job            (jif),
    .core_rst       (core_rst),
    .core_start     (core_start),
    .core_rd_addr_q (c_aq),
    .core_rd_addr_p (c_ap),
    .core_res_addr  (c_ra),
    .core_res_we    (c_we),
    .core_res_data  (c_rd),
    .mem_q_addr     (mem_q_addr),
    .mem_p_addr     (mem_p_addr),
    .res_addr       (res_addr),
    .res_we         (res_we),
    .res_data       (res_data)
  );

  logic [29:0] bank_q [DEPTH];
  logic [29:0] bank_p [DEPTH];
  logic [29:0] res_mem [DEPTH];
  logic [29:0] q_rd, p_rd;

  always @(posedge clk) begin
    q_rd <= bank_q[mem_q_addr];
    p_rd <= bank_p[mem_p_addr];
    if (res_we) res_mem[res_addr] <= res_data;
  end

  // Core stand-in: per set, read q0..5/p0..6, then write 7 results p[a]+q[min(a,5)].
  logic        stub_nowrite = 1'b0;
  logic        c_wphase;
  int          c_cnt;
  logic [29:0] cap_q [7];
  logic [29:0] cap_p [7];

  always @(posedge clk) begin
    if (core_rst || !core_start) begin
      c_wphase <= 1'b0; c_cnt <= 0; c_aq <= '0; c_ap <= '0;
      c_ra <= '0; c_we <= 1'b0; c_rd <= '0;
    end else if (!c_wphase) begin
      if (c_cnt <= 6) begin
        c_ap <= 3'(c_cnt);
        c_aq <= (c_cnt > 5) ? LIFT_Q_LAST : 3'(c_cnt);
      end else begin
        c_ap <= '0; c_aq <= '0;
      end
      if (c_cnt >= 2) begin
        cap_p[c_cnt-2] <= p_rd;
        if (c_cnt <= 7) cap_q[c_cnt-2] <= q_rd;
      end
      if (c_cnt == 8) begin c_wphase <= 1'b1; c_cnt <= 0; end
      else c_cnt <= c_cnt + 1;
    end else begin
      if (c_cnt <= 6) begin
        c_ra <= 3'(c_cnt);
        c_we <= !stub_nowrite;
        c_rd <= cap_p[c_cnt] + cap_q[(c_cnt > 5) ? 5 : c_cnt];
      end else begin
        c_we <= 1'b0;
      end
      if (c_cnt == 7) begin c_wphase <= 1'b0; c_cnt <= 0; end
      else c_cnt <= c_cnt + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int max_p_idx = 0;
  logic [CW+2:0] exp_addr [$];
  logic [29:0]   exp_data [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every bank write must match the next queued expectation.
  always @(negedge clk) begin
    if (res_we) begin
      n_cmp++;
      if (exp_addr.size() == 0) begin
        n_err++;
        $display("[TB] FAIL sb_extra: write addr=%0h data=%0h, required no write", res_addr, res_data);
      end else begin
        logic [CW+2:0] ea;
        logic [29:0]   ed;
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        if (res_addr !== ea || res_data !== ed) begin
          n_err++;
          $display("[TB] FAIL sb_write: addr=%0h data=%0h, required addr=%0h data=%0h",
                   res_addr, res_data, ea, ed);
        end
      end
    end
    if (jif.job_done) done_cnt++;
    if (jif.job_busy && int'(mem_p_addr[CW+2:3]) > max_p_idx) max_p_idx = int'(mem_p_addr[CW+2:3]);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "[TB] global timeout");
  end

  task automatic init_banks();
    logic [29:0] q0 [6];
    logic [29:0] p0 [7];
    q0 = '{30'd619584084, 30'd758639283, 30'd1026829706, 30'd778998210, 30'd302009656, 30'd836990255};
    p0 = '{30'd478083334, 30'd787022829, 30'd684505315, 30'd93050313, 30'd137113526,
           30'd809985067, 30'd102873779};
    for (int k = 0; k < NMAX; k++) begin
      for (int i = 0; i < 8; i++) begin
        bank_q[k*8+i] = (i < 6) ? q0[(i+k)%6] : 30'd0;
        bank_p[k*8+i] = (i < 7) ? p0[(i+k)%7] : 30'd0;
      end
    end
  endtask

  task automatic push_job(input int num);
    for (int idx = 0; idx < num; idx++) begin
      for (int a = 0; a < 7; a++) begin
        exp_addr.push_back((CW+3)'(idx*8 + a));
        exp_data.push_back(bank_p[idx*8+a] + bank_q[idx*8 + ((a > 5) ? 5 : a)]);
      end
    end
  endtask

  task automatic start_job(input int num);
    jif.job_num   = (CW+1)'(num);
    jif.job_start = 1'b1;
    @(negedge clk);
    jif.job_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (jif.job_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({core_rst, core_start, jif.job_busy, jif.job_done, jif.job_err, res_we} !== 6'b100000) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got %b, required 100000",
               {core_rst, core_start, jif.job_busy, jif.job_done, jif.job_err, res_we});
    end
    n_cmp++;
    if (mem_p_addr[CW+2:3] !== '0 || res_addr[CW+2:3] !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_idx: rd=%0d wr=%0d, required 0/0", mem_p_addr[CW+2:3], res_addr[CW+2:3]);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int rc = 0;
    bit ok;
    done_cnt = 0;
    push_job(1);
    start_job(1);
    while (jif.job_busy && core_rst && rc < 10) begin rc++; @(negedge clk); end
    n_cmp++;
    if (rc != 2) begin n_err++; $display("[TB] FAIL crst_len: %0d cycles, required 2", rc); end
    n_cmp++;
    if ({jif.job_busy, core_rst, core_start} !== 3'b100) begin
      n_err++; $display("[TB] FAIL crel: busy/rst/start=%b, required 100", {jif.job_busy, core_rst, core_start});
    end
    @(negedge clk);
    n_cmp++;
    if (core_start !== 1'b1) begin n_err++; $display("[TB] FAIL run_start: %b, required 1", core_start); end
    wait_done(300, ok);
    n_cmp++;
    if (!ok || jif.job_busy !== 1'b0) begin
      n_err++; $display("[TB] FAIL single_done: seen=%0d busy=%b, required 1/0", ok, jif.job_busy);
    end
    @(negedge clk);
    n_cmp++;
    if (jif.job_done !== 1'b0 || core_rst !== 1'b1) begin
      n_err++; $display("[TB] FAIL done_pulse: done=%b rst=%b, required 0/1", jif.job_done, core_rst);
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (exp_addr.size() != 0 || done_cnt != 1) begin
      n_err++; $display("[TB] FAIL single_end: left=%0d dones=%0d, required 0/1", exp_addr.size(), done_cnt);
    end
  endtask

  task automatic test_three();
    bit ok;
    done_cnt = 0;
    max_p_idx = 0;
    push_job(3);
    start_job(3);
    wait_done(500, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("[TB] FAIL three_done: not seen, required done"); end
    repeat (30) @(negedge clk);
    n_cmp++;
    if (max_p_idx != 2) begin n_err++; $display("[TB] FAIL three_rdidx: max=%0d, required 2", max_p_idx); end
    n_cmp++;
    if (exp_addr.size() != 0 || done_cnt != 1) begin
      n_err++; $display("[TB] FAIL three_end: left=%0d dones=%0d, required 0/1", exp_addr.size(), done_cnt);
    end
  endtask

  task automatic test_zero();
    done_cnt = 0;
    start_job(0);
    n_cmp++;
    if ({jif.job_done, core_rst, jif.job_busy} !== 3'b110) begin
      n_err++; $display("[TB] FAIL zero_done: done/rst/busy=%b, required 110", {jif.job_done, core_rst, jif.job_busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({jif.job_done, core_rst, jif.job_busy} !== 3'b010) begin
      n_err++; $display("[TB] FAIL zero_after: done/rst/busy=%b, required 010", {jif.job_done, core_rst, jif.job_busy});
    end
  endtask

  task automatic test_timeout();
    int t0 = -1;
    int t1 = -1;
    bit ok;
    stub_nowrite = 1'b1;
    start_job(1);
    for (int i = 0; i < 20; i++) begin
      if (core_start) begin t0 = cyc; break; end
      @(negedge clk);
    end
    for (int i = 0; i < 200; i++) begin
      if (jif.job_err) begin t1 = cyc; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (t0 < 0 || t1 < 0 || t1 - t0 != TO) begin
      n_err++; $display("[TB] FAIL wdog_time: run=%0d err=%0d, required err-run=%0d", t0, t1, TO);
    end
    n_cmp++;
    if ({jif.job_busy, core_rst, res_we} !== 3'b010) begin
      n_err++; $display("[TB] FAIL wdog_state: busy/rst/we=%b, required 010", {jif.job_busy, core_rst, res_we});
    end
    stub_nowrite = 1'b0;
    done_cnt = 0;
    push_job(1);
    start_job(1);
    n_cmp++;
    if (jif.job_err !== 1'b0 || jif.job_busy !== 1'b1) begin
      n_err++; $display("[TB] FAIL err_clear: err=%b busy=%b, required 0/1", jif.job_err, jif.job_busy);
    end
    wait_done(300, ok);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (!ok || exp_addr.size() != 0 || done_cnt != 1) begin
      n_err++; $display("[TB] FAIL err_rerun: seen=%0d left=%0d dones=%0d, required 1/0/1", ok, exp_addr.size(), done_cnt);
    end
  endtask

  task automatic test_abort();
    int nw = 0;
    bit hit = 1'b0;
    bit ok;
    done_cnt = 0;
    push_job(2);
    start_job(4);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (res_we && res_addr[2:0] == 3'd6) begin
        nw++;
        if (nw == 2) begin hit = 1'b1; break; end
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!hit || {core_rst, core_start, jif.job_busy, jif.job_done, jif.job_err, res_we} !== 6'b100000) begin
      n_err++;
      $display("[TB] FAIL abort_outputs: hit=%0d got %b, required 1/100000", hit,
               {core_rst, core_start, jif.job_busy, jif.job_done, jif.job_err, res_we});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done_cnt != 0 || exp_addr.size() != 0) begin
      n_err++; $display("[TB] FAIL abort_nodone: dones=%0d left=%0d, required 0/0", done_cnt, exp_addr.size());
    end
    push_job(4);
    start_job(4);
    wait_done(600, ok);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (!ok || exp_addr.size() != 0 || done_cnt != 1) begin
      n_err++; $display("[TB] FAIL abort_rerun: seen=%0d left=%0d dones=%0d, required 1/0/1", ok, exp_addr.size(), done_cnt);
    end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    done_cnt = 0;
    push_job(1);
    start_job(1);
    repeat (5) @(negedge clk);
    start_job(2);
    wait_done(300, ok);
    repeat (40) @(negedge clk);
    n_cmp++;
    if (!ok || done_cnt != 1 || exp_addr.size() != 0 || jif.job_busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL busy_ignore: seen=%0d dones=%0d left=%0d busy=%b, required 1/1/0/0",
               ok, done_cnt, exp_addr.size(), jif.job_busy);
    end
  endtask

  task automatic test_overflow();
    start_job(NMAX + 1);
    n_cmp++;
    if ({jif.job_err, core_rst, jif.job_busy} !== 3'b110) begin
      n_err++; $display("[TB] FAIL overflow: err/rst/busy=%b, required 110", {jif.job_err, core_rst, jif.job_busy});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({jif.job_err, core_rst, jif.job_busy} !== 3'b110) begin
      n_err++; $display("[TB] FAIL err_sticky: err/rst/busy=%b, required 110", {jif.job_err, core_rst, jif.job_busy});
    end
  endtask

  initial begin
    jif.job_start = 1'b0;
    jif.job_num   = '0;
    init_banks();
    test_reset();
    test_single();
    test_three();
    test_zero();
    test_timeout();
    test_abort();
    test_busy_ignore();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
